// File: rtl/flt2int.sv
// flt2int: half-precision float to 16-bit integer converter.
// Reads a float from data_mem1 (bytes 1:0) and writes the rounded
// two's-complement integer back to bytes 3:2 (round half to even).
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous active-low reset
//   start - request; memory is loaded while high, conversion runs
//           after it drops
//   done  - result valid; held until the next start is seen
// Build option:
//   FLT2INT_SAT_EN - overflow/Inf/NaN saturate by sign instead of
//                    returning the integer-indefinite 16'h8000

module data_mem (
    input  logic       clk,
    input  logic       i_we,
    input  logic [7:0] i_addr,
    input  logic [7:0] i_wdata,
    output logic [7:0] o_rdata
);
    logic [7:0] mem_core [0:255];

    always_ff @(posedge clk) begin
        if (i_we)
            mem_core[i_addr] <= i_wdata;
    end

    assign o_rdata = mem_core[i_addr];
endmodule

module flt2int (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic done
);
    typedef enum logic [3:0] {
        S_IDLE, S_ARM, S_LD_HI, S_LD_LO, S_CLASS, S_SHIFT,
        S_ROUND, S_NEG, S_WR_LO, S_WR_HI, S_DONE
    } state_t;

    state_t      r_state, w_next;
    logic [15:0] r_flt;
    logic [15:0] r_mag;
    logic        r_guard, r_sticky;
    logic        r_left, r_spec, r_done;
    logic [3:0]  r_cnt;

    logic        w_we;
    logic [7:0]  w_addr, w_wdata, w_rdata;

    logic        w_sign;
    logic [4:0]  w_exp;
    logic [9:0]  w_frac;

    logic [15:0] w_cls_mag;
    logic [3:0]  w_cls_cnt;
    logic        w_cls_left, w_cls_spec;

    assign w_sign = r_flt[15];
    assign w_exp  = r_flt[14:10];
    assign w_frac = r_flt[9:0];
    assign done   = r_done;

    data_mem data_mem1 (
        .clk     (clk),
        .i_we    (w_we),
        .i_addr  (w_addr),
        .i_wdata (w_wdata),
        .o_rdata (w_rdata)
    );

    // Classification. Mantissa M={1,frac} has weight 2^(e-25), so
    // e=25 needs no shift. e=30/sign=1/frac=0 (-32768) lands on
    // 16'h8000 through the special path in both builds.
    always_comb begin
        w_cls_mag  = 16'd0;
        w_cls_cnt  = 4'd0;
        w_cls_left = 1'b0;
        w_cls_spec = 1'b0;
        if (w_exp >= 5'd30) begin
            w_cls_spec = 1'b1;
`ifdef FLT2INT_SAT_EN
            w_cls_mag  = w_sign ? 16'h8000 : 16'h7FFF;
`else
            w_cls_mag  = 16'h8000;
`endif
        end else if (w_exp >= 5'd14) begin
            w_cls_mag = {5'd0, 1'b1, w_frac};
            if (w_exp > 5'd25) begin
                w_cls_left = 1'b1;
                w_cls_cnt  = 4'(w_exp - 5'd25);
            end else begin
                w_cls_cnt  = 4'(5'd25 - w_exp);
            end
        end
    end

    always_comb begin
        w_next  = r_state;
        w_we    = 1'b0;
        w_addr  = 8'd0;
        w_wdata = 8'd0;
        unique case (r_state)
            S_IDLE:  if (start) w_next = S_ARM;
            S_ARM:   if (!start) w_next = S_LD_HI;
            S_LD_HI: begin
                w_addr = 8'd1;
                w_next = S_LD_LO;
            end
            S_LD_LO: begin
                w_addr = 8'd0;
                w_next = S_CLASS;
            end
            S_CLASS: w_next = (w_cls_cnt == 4'd0) ? S_ROUND : S_SHIFT;
            S_SHIFT: if (r_cnt == 4'd1) w_next = S_ROUND;
            S_ROUND: w_next = S_NEG;
            S_NEG:   w_next = S_WR_LO;
            S_WR_LO: begin
                w_we    = 1'b1;
                w_addr  = 8'd2;
                w_wdata = r_mag[7:0];
                w_next  = S_WR_HI;
            end
            S_WR_HI: begin
                w_we    = 1'b1;
                w_addr  = 8'd3;
                w_wdata = r_mag[15:8];
                w_next  = S_DONE;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_flt    <= 16'd0;
            r_mag    <= 16'd0;
            r_guard  <= 1'b0;
            r_sticky <= 1'b0;
            r_left   <= 1'b0;
            r_spec   <= 1'b0;
            r_cnt    <= 4'd0;
            r_done   <= 1'b0;
        end else begin
            r_state <= w_next;
            unique case (r_state)
                S_IDLE:  if (start) r_done <= 1'b0;
                S_LD_HI: r_flt[15:8] <= w_rdata;
                S_LD_LO: r_flt[7:0]  <= w_rdata;
                S_CLASS: begin
                    r_mag    <= w_cls_mag;
                    r_cnt    <= w_cls_cnt;
                    r_left   <= w_cls_left;
                    r_spec   <= w_cls_spec;
                    r_guard  <= 1'b0;
                    r_sticky <= 1'b0;
                end
                S_SHIFT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_left) begin
                        r_mag <= r_mag << 1;
                    end else begin
                        r_mag    <= r_mag >> 1;
                        r_guard  <= r_mag[0];
                        r_sticky <= r_sticky | r_guard;
                    end
                end
                S_ROUND: begin
                    if (r_guard && (r_sticky || r_mag[0]))
                        r_mag <= r_mag + 16'd1;
                end
                // Special results already hold their final encoding.
                S_NEG: begin
                    if (w_sign && !r_spec)
                        r_mag <= ~r_mag + 16'd1;
                end
                S_DONE:  r_done <= 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: doc/flt2int.md
# flt2int

Sequential half-precision-to-integer converter, the inverse of the int2flt program. On a start/done handshake it reads a 16-bit float (1 sign, 5-bit exponent biased by 15, 10-bit fraction with hidden 1) from its internal data memory. It then writes the rounded 16-bit two's-complement integer back to that memory. It sits beside int2flt so the two can be chained for round-trip checks.

## Interface
- No parameters. Memory is fixed at 256 x 8, instance data_mem1, array mem_core.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  request; bench loads memory while high
- done  out  1  conversion complete; held until next start

## Operation
- Memory map:
  - float input at mem_core[1] (hi), mem_core[0] (lo);
  - integer result at mem_core[3] (hi), mem_core[2] (lo).
  - Read is combinational; write is synchronous.
  - Reset does not clear memory.
- FSM states and transitions:
  - IDLE -> ARM on start=1. Entering ARM clears done.
  - ARM: wait for start=0.
  - ARM -> LD_HI -> LD_LO -> CLASS -> SHIFT (n cycles) -> ROUND -> NEG -> WR_LO -> WR_HI -> DONE.
  - DONE sets done=1 and returns to IDLE.
- CLASS, with e = exponent:
  - e<14: zero or denormal; result 0; n=0.
  - 14<=e<=29: load M={1,frac} (11 bits). Set n=|e-25|, direction left if e>25, right if e<25.
  - e=30, sign=1, frac=0: result 16'h8000 exactly.
  - Any other e>=30: overflow/Inf/NaN, handled per Configuration.
- SHIFT: one bit per cycle in a 16-bit magnitude register.
  - Right shifts move the outgoing bit into guard; the previous guard ORs into sticky.
  - Left shifts fill with zeros.
- ROUND: round half to even.
  - Increment if guard & (sticky | lsb).
  - The e=14 case yields guard=1, sticky=(frac!=0), magnitude 0.
- NEG: if sign=1, result = ~mag+1. Negative zero gives 0.
- Maximum finite magnitude is 32752 (e=29, frac=3FF), so no overflow is possible for e<=29.
- start asserted while busy (not IDLE/ARM/DONE) is ignored. Only a start seen in IDLE launches a conversion.

## Timing
- Reset values:
  - done=0, state IDLE;
  - magnitude, guard, sticky, count all 0.
  - No memory write enable is asserted during reset.
- Latency is counted from the first clk edge with start=0 in ARM: done rises 8+n cycles later.
  - n ranges 0..11, so latency is 8..19 cycles.
  - Special cases always use n=0.
- WR_LO writes mem_core[2] and WR_HI writes mem_core[3], on consecutive edges.
- done rises on the edge after WR_HI, so both bytes are valid when done=1.
- done stays 1 until the cycle after start is next sampled high.
- reset asserted mid-operation aborts immediately to IDLE with done=0.
  - If the abort lands before WR_LO, the output bytes are untouched.
  - If it lands between WR_LO and WR_HI, only byte 2 is updated; this is permitted, and done=0 marks the result invalid.

## Configuration
- FLT2INT_SAT_EN defined: overflow, Inf and NaN saturate to 16'h7FFF when sign=0 and 16'h8000 when sign=1.
- FLT2INT_SAT_EN undefined: every e>=30 input except the exact 16'h F800 case writes the integer-indefinite value 16'h8000.
- Latency is identical either way.

## Test plan
- Simple values: 16'h3C00 (1.0) -> 16'h0001, latency 8+11... no: e=15, n=10, so 18 cycles. 16'h6400 (1024.0, e=25) -> 16'h0400, latency 8 cycles.
- Ties to even: 16'h4100 (2.5) -> 16'h0002; 16'h4300 (3.5) -> 16'h0004; 16'h3E00 (1.5) -> 16'h0002.
- Sub-one values: 16'h3800 (0.5) -> 16'h0000; 16'h3801 -> 16'h0001; 16'h0001 (denormal) -> 16'h0000; 16'h8000 (-0) -> 16'h0000.
- Range extremes: 16'h77FF -> 16'h7FF0; 16'hF7FF -> 16'h8010; 16'hF800 -> 16'h8000.
- Overflow: 16'h7800 and 16'h7C00 -> 16'h7FFF with FLT2INT_SAT_EN, 16'h8000 without. 16'hFE00 (NaN) -> 16'h8000 in both builds.
- Control: pulse start during SHIFT -> ignored; result and latency unchanged. Assert reset during SHIFT -> done=0, state IDLE, mem_core[3:2] unchanged; the next start/convert succeeds.
